// File: rtl/line_mem_responder.sv
// Pipelined Wishbone slave serving 128-bit line reads/writes from an internal store,
// with fixed response latency, in-order ack/err and a bounded number of outstanding requests.
module line_mem_responder #(
  parameter int DEPTH           = 256,
  parameter int AW              = 30,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [15:0]   wb_sel_i,
  input  logic [127:0]  wb_wdata_i,
  output logic [127:0]  wb_rdata_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_stall_o,
  output logic          wb_rty_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [127:0]       r_mem [DEPTH] = '{default: '0};
  logic [CW-1:0]      r_cnt;
  logic [LATENCY-1:0] r_pv;
  logic [LATENCY-1:0] r_perr;
  logic [127:0]       r_pdata [LATENCY];

  logic               w_accept;
  logic               w_in_range;
  logic               w_rsp_next;
  logic [IW-1:0]      w_idx;
  logic [127:0]       w_rd_line;

  assign wb_stall_o = (r_cnt == CW'(MAX_OUTSTANDING));
  assign w_accept   = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign w_in_range = (64'(wb_addr_i) < 64'(DEPTH));
  assign w_idx      = wb_addr_i[IW-1:0];
  assign w_rd_line  = r_mem[w_idx];

  // A response leaves the pipe on the edge it enters the last stage; that edge retires it.
  if (LATENCY == 1) begin : g_lat1
    assign w_rsp_next = w_accept;
  end else begin : g_latn
    assign w_rsp_next = r_pv[LATENCY-2];
  end

  always_ff @(posedge clk_i) begin
    if (w_accept && wb_we_i && w_in_range) begin
      for (int b = 0; b < 16; b++) begin
        if (wb_sel_i[b]) r_mem[w_idx][8*b +: 8] <= wb_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_pv   <= '0;
      r_perr <= '0;
      for (int i = 0; i < LATENCY; i++) r_pdata[i] <= '0;
    end else if (!wb_cyc_i) begin
      r_cnt  <= '0;
      r_pv   <= '0;
      r_perr <= '0;
      for (int i = 0; i < LATENCY; i++) r_pdata[i] <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        r_pv[i]    <= r_pv[i-1];
        r_perr[i]  <= r_perr[i-1];
        r_pdata[i] <= r_pdata[i-1];
      end
      r_pv[0]    <= w_accept;
      r_perr[0]  <= w_accept & ~w_in_range;
      r_pdata[0] <= (w_accept && !wb_we_i && w_in_range) ? w_rd_line : '0;
      if (w_accept && !w_rsp_next) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (!w_accept && w_rsp_next) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign wb_ack_o   = r_pv[LATENCY-1] & ~r_perr[LATENCY-1];
  assign wb_err_o   = r_pv[LATENCY-1] &  r_perr[LATENCY-1];
  assign wb_rdata_o = r_pdata[LATENCY-1];
  assign wb_rty_o   = 1'b0;

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: two instances (LATENCY=2/MAX=2/DEPTH=256 and
// LATENCY=3/MAX=1/DEPTH=5) driven by a shared request task and checked at the falling edge.
module tb_line_mem_responder;
  localparam int AW = 30;

  typedef struct {
    logic         err;
    logic [127:0] data;
    int           due;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          cyc_a   [2];
  logic          stb_a   [2];
  logic          we_a    [2];
  logic [AW-1:0] adr_a   [2];
  logic [15:0]   sel_a   [2];
  logic [127:0]  wd_a    [2];
  logic [127:0]  rd_a    [2];
  logic          ack_a   [2];
  logic          err_a   [2];
  logic          stall_a [2];
  logic          rty_a   [2];

  rsp_t         q0 [$];
  rsp_t         q1 [$];
  logic [127:0] mdl [2][256];
  int           cyc_cnt   = 0;
  int           n_chk     = 0;
  int           n_pass    = 0;
  bit           gap_on    = 1'b0;
  int           last_ack1 = -1;

  line_mem_responder #(.DEPTH(256), .AW(AW), .LATENCY(2), .MAX_OUTSTANDING(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(cyc_a[0]), .wb_stb_i(stb_a[0]), .wb_we_i(we_a[0]), .wb_addr_i(adr_a[0]),
    .wb_sel_i(sel_a[0]), .wb_wdata_i(wd_a[0]), .wb_rdata_o(rd_a[0]), .wb_ack_o(ack_a[0]),
    .wb_err_o(err_a[0]), .wb_stall_o(stall_a[0]), .wb_rty_o(rty_a[0])
  );

  line_mem_responder #(.DEPTH(5), .AW(AW), .LATENCY(3), .MAX_OUTSTANDING(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(cyc_a[1]), .wb_stb_i(stb_a[1]), .wb_we_i(we_a[1]), .wb_addr_i(adr_a[1]),
    .wb_sel_i(sel_a[1]), .wb_wdata_i(wd_a[1]), .wb_rdata_o(rd_a[1]), .wb_ack_o(ack_a[1]),
    .wb_err_o(err_a[1]), .wb_stall_o(stall_a[1]), .wb_rty_o(rty_a[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? 256 : 5;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push(input int d, input rsp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic mon(input int d);
    rsp_t e;
    int   sz;
    sz = (d == 0) ? q0.size() : q1.size();
    if (rty_a[d] !== 1'b0) chk($sformatf("rty%0d", d), rty_a[d], 0);
    if (ack_a[d] || err_a[d]) begin
      if (sz == 0) begin
        chk($sformatf("spurious%0d", d), 1, 0);
      end else begin
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("ack%0d", d), ack_a[d], !e.err);
        chk($sformatf("err%0d", d), err_a[d], e.err);
        chk($sformatf("rdata%0d", d), rd_a[d], e.data);
        chk($sformatf("latency%0d", d), cyc_cnt, e.due);
        if (d == 1 && gap_on) begin
          if (last_ack1 >= 0) chk("ack_gap1", cyc_cnt - last_ack1, 3);
          last_ack1 = cyc_cnt;
        end
      end
    end else begin
      if (rd_a[d] != '0) chk($sformatf("rdata_idle%0d", d), rd_a[d], 0);
      if (sz > 0) begin
        e = (d == 0) ? q0[0] : q1[0];
        if (e.due < cyc_cnt) begin
          chk($sformatf("missing%0d", d), 1, 0);
          if (d == 0) void'(q0.pop_front());
          else void'(q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0);
      mon(1);
    end
  end

  task automatic req(input int d, input logic we, input logic [AW-1:0] a,
                     input logic [15:0] sel, input logic [127:0] wd);
    logic st;
    bit   done;
    rsp_t e;
    int   ai;
    done     = 1'b0;
    cyc_a[d] = 1'b1;
    stb_a[d] = 1'b1;
    we_a[d]  = we;
    adr_a[d] = a;
    sel_a[d] = sel;
    wd_a[d]  = wd;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      st = stall_a[d];
      @(posedge clk);
      #1;
      if (!st) done = 1'b1;
    end
    if (!done) begin
      chk($sformatf("accept_timeout%0d", d), 1, 0);
      stb_a[d] = 1'b0;
      return;
    end
    ai    = int'(a);
    e.due = cyc_cnt + lat_of(d) - 1;
    e.err = (ai >= depth_of(d));
    if (!e.err && we) begin
      for (int b = 0; b < 16; b++) begin
        if (sel[b]) mdl[d][ai][8*b +: 8] = wd[8*b +: 8];
      end
    end
    e.data = (!e.err && !we) ? mdl[d][ai] : '0;
    push(d, e);
  endtask

  task automatic idle(input int d);
    stb_a[d] = 1'b0;
    we_a[d]  = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drops cyc; only the response already on the bus this cycle survives the abort.
  task automatic abort(input int d);
    cyc_a[d] = 1'b0;
    stb_a[d] = 1'b0;
    if (d == 0) begin
      while (q0.size() > 0 && q0[$].due > cyc_cnt) void'(q0.pop_back());
    end else begin
      while (q1.size() > 0 && q1[$].due > cyc_cnt) void'(q1.pop_back());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] rdat;
    logic [AW-1:0] radr;
    for (int d = 0; d < 2; d++) begin
      cyc_a[d] = 1'b0; stb_a[d] = 1'b0; we_a[d] = 1'b0;
      adr_a[d] = '0; sel_a[d] = '0; wd_a[d] = '0;
      for (int i = 0; i < 256; i++) mdl[d][i] = '0;
    end

    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ack%0d", d), ack_a[d], 0);
      chk($sformatf("rst_err%0d", d), err_a[d], 0);
      chk($sformatf("rst_stall%0d", d), stall_a[d], 0);
      chk($sformatf("rst_rdata%0d", d), rd_a[d], 0);
    end
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rel_stall0", stall_a[0], 0);
    chk("rel_stall1", stall_a[1], 0);
    cyc_a[0] = 1'b1;
    cyc_a[1] = 1'b1;
    wait_cyc(1);

    req(0, 1'b1, 30'h05, 16'hFFFF, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    req(0, 1'b0, 30'h05, 16'h0000, '0);
    idle(0); wait_cyc(4);

    req(0, 1'b1, 30'h10, 16'h000F, {128{1'b1}});
    req(0, 1'b0, 30'h10, 16'h0000, '0);
    idle(0); wait_cyc(4);

    req(0, 1'b1, 30'h100, 16'hFFFF, 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0);
    req(0, 1'b0, 30'h100, 16'h0000, '0);
    req(0, 1'b0, 30'h00, 16'h0000, '0);
    idle(0); wait_cyc(4);

    req(0, 1'b1, 30'h05, 16'h0000, {128{1'b1}});
    req(0, 1'b0, 30'h05, 16'h0000, '0);
    idle(0); wait_cyc(4);

    gap_on = 1'b1;
    req(1, 1'b0, 30'h0, 16'h0, '0);
    chk("stall_hold_a", stall_a[1], 1);
    req(1, 1'b0, 30'h1, 16'h0, '0);
    chk("stall_hold_b", stall_a[1], 1);
    req(1, 1'b0, 30'h2, 16'h0, '0);
    chk("stall_hold_c", stall_a[1], 1);
    idle(1); wait_cyc(6);
    gap_on = 1'b0;

    req(1, 1'b1, 30'h4, 16'hFFFF, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    req(1, 1'b0, 30'h4, 16'h0, '0);
    req(1, 1'b1, 30'h5, 16'hFFFF, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000);
    req(1, 1'b0, 30'h5, 16'h0, '0);
    req(1, 1'b0, 30'h0, 16'h0, '0);
    idle(1); wait_cyc(6);

    for (int n = 0; n < 24; n++) begin
      rdat = {$urandom, $urandom, $urandom, $urandom};
      radr = ($urandom_range(0, 7) == 0) ? AW'(30'h100 + $urandom_range(0, 3))
                                         : AW'($urandom_range(0, 15));
      req(0, 1'($urandom_range(0, 1)), radr, 16'($urandom), rdat);
      if ($urandom_range(0, 2) == 0) begin
        idle(0);
        wait_cyc(1);
      end
    end
    idle(0); wait_cyc(6);

    req(0, 1'b0, 30'h01, 16'h0, '0);
    req(0, 1'b0, 30'h02, 16'h0, '0);
    abort(0);
    wait_cyc(4);
    chk("abort_stall0", stall_a[0], 0);
    cyc_a[0] = 1'b1;
    req(0, 1'b0, 30'h05, 16'h0, '0);
    idle(0); wait_cyc(4);

    req(1, 1'b0, 30'h01, 16'h0, '0);
    abort(1);
    wait_cyc(4);
    chk("abort_stall1", stall_a[1], 0);
    cyc_a[1] = 1'b1;
    req(1, 1'b0, 30'h04, 16'h0, '0);
    idle(1); wait_cyc(6);

    req(1, 1'b0, 30'h0, 16'h0, '0);
    idle(1);
    req(0, 1'b0, 30'h05, 16'h0, '0);
    idle(0);
    @(posedge clk);
    #2;
    chk("pre_rst_ack0", ack_a[0], 1);
    chk("pre_rst_ack1", ack_a[1], 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ack0", ack_a[0], 0);
    chk("mid_rst_ack1", ack_a[1], 0);
    chk("mid_rst_rdata0", rd_a[0], 0);
    chk("mid_rst_stall1", stall_a[1], 0);
    q0.delete();
    q1.delete();
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    wait_cyc(6);
    req(0, 1'b0, 30'h05, 16'h0, '0);
    req(0, 1'b0, 30'h10, 16'h0, '0);
    idle(0);
    req(1, 1'b0, 30'h04, 16'h0, '0);
    idle(1);
    wait_cyc(8);

    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
